// File: rtl/vga_controller_if.sv
// Video timing bundle from the VGA controller to the pixel/glyph generator.
// The master side drives sync, blanking and the current screen coordinates.
interface vga_controller_if;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic [9:0] hCount;
    logic [9:0] vCount;

    modport master (output hSync, output vSync, output bright, output hCount, output vCount);
    modport slave  (input  hSync, input  vSync, input  bright, input  hCount, input  vCount);
endinterface

// File: rtl/vga_controller.sv
// VGA timing generator: a pixel-rate divider drives column/line counters.
// Sync and blanking are zero-latency decodes of those counters.
module vga_controller #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned CLK_DIV   = 4
) (
    input  logic              clock,
    input  logic              clear,
    vga_controller_if.master  vga
);
    localparam int unsigned CNT_W    = 10;
    localparam int unsigned DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START = H_VISIBLE + H_FRONT;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_VISIBLE + V_FRONT;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] h_q, h_d;
    logic [CNT_W-1:0] v_q, v_d;
    logic             tick;

    // With CLK_DIV == 1 the divider sits at 0 and every clock is a tick.
    assign tick = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        div_d = div_q;
        h_d   = h_q;
        v_d   = v_q;
        if (tick) begin
            div_d = '0;
            if (h_q == CNT_W'(H_TOTAL - 1)) begin
                h_d = '0;
                if (v_q == CNT_W'(V_TOTAL - 1)) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 1'b1;
                end
            end else begin
                h_d = h_q + 1'b1;
            end
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
        end
    end

    // Decodes track the counters in the same cycle; bright is forced low during clear.
    assign vga.hCount = h_q;
    assign vga.vCount = v_q;
    assign vga.hSync  = !((h_q >= CNT_W'(HS_START)) && (h_q < CNT_W'(HS_END)));
    assign vga.vSync  = !((v_q >= CNT_W'(VS_START)) && (v_q < CNT_W'(VS_END)));
    assign vga.bright = !clear && (h_q < CNT_W'(H_VISIBLE)) && (v_q < CNT_W'(V_VISIBLE));
endmodule

// File: tb/tb_vga_controller.sv
// Directed and every-cycle checks of vga_controller at default timing, CLK_DIV=1,
// and a shrunken timing build where whole frames fit in a short run.
module tb_vga_controller;
    logic clock = 1'b0;
    logic clr_a;
    logic clr_b;
    logic clr_c;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    vga_controller_if if_a ();
    vga_controller_if if_b ();
    vga_controller_if if_c ();

    vga_controller u_a (.clock(clock), .clear(clr_a), .vga(if_a.master));

    vga_controller #(.CLK_DIV(1)) u_b (.clock(clock), .clear(clr_b), .vga(if_b.master));

    // 15 pixels x 8 lines, 2 clocks per pixel: hSync low at 10..12, vSync low at 5..6.
    vga_controller #(
        .H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
        .V_VISIBLE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
        .CLK_DIV(2)
    ) u_c (.clock(clock), .clear(clr_c), .vga(if_c.master));

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Independent position model: k clocks after clear release.
    task automatic check_port(input string pfx, input int k,
                              input int hv, input int hf, input int hs, input int hb,
                              input int vv, input int vf, input int vs, input int vb,
                              input int div,
                              input int oh, input int ov, input int ohs, input int ovs,
                              input int obr);
        int ht, vt, pix, h, v, ehs, evs, ebr;
        ht  = hv + hf + hs + hb;
        vt  = vv + vf + vs + vb;
        pix = k / div;
        h   = pix % ht;
        v   = (pix / ht) % vt;
        ehs = (h >= hv + hf && h < hv + hf + hs) ? 0 : 1;
        evs = (v >= vv + vf && v < vv + vf + vs) ? 0 : 1;
        ebr = (h < hv && v < vv) ? 1 : 0;
        check({pfx, "_hcount"}, oh, h);
        check({pfx, "_vcount"}, ov, v);
        check({pfx, "_hsync"}, ohs, ehs);
        check({pfx, "_vsync"}, ovs, evs);
        check({pfx, "_bright"}, obr, ebr);
    endtask

    task automatic chk_a(input string tag, input int h, input int v, input int hs,
                         input int vs, input int br);
        check({tag, "_h"}, int'(if_a.hCount), h);
        check({tag, "_v"}, int'(if_a.vCount), v);
        check({tag, "_hs"}, int'(if_a.hSync), hs);
        check({tag, "_vs"}, int'(if_a.vSync), vs);
        check({tag, "_br"}, int'(if_a.bright), br);
    endtask

    task automatic chk_b(input string tag, input int h, input int v, input int hs,
                         input int br);
        check({tag, "_h"}, int'(if_b.hCount), h);
        check({tag, "_v"}, int'(if_b.vCount), v);
        check({tag, "_hs"}, int'(if_b.hSync), hs);
        check({tag, "_br"}, int'(if_b.bright), br);
    endtask

    task automatic chk_c(input string tag, input int h, input int v, input int vs,
                         input int br);
        check({tag, "_h"}, int'(if_c.hCount), h);
        check({tag, "_v"}, int'(if_c.vCount), v);
        check({tag, "_vs"}, int'(if_c.vSync), vs);
        check({tag, "_br"}, int'(if_c.bright), br);
    endtask

    initial begin
        clr_a = 1'b1;
        clr_b = 1'b1;
        clr_c = 1'b1;
        #20;
        chk_a("reset_a", 0, 0, 1, 1, 0);
        chk_c("reset_c", 0, 0, 1, 0);

        @(negedge clock);
        clr_a = 1'b0;
        clr_b = 1'b0;
        clr_c = 1'b0;

        for (int k = 0; k < 12400; k++) begin
            #1;
            check_port("a", k, 640, 16, 96, 48, 480, 10, 2, 33, 4,
                       int'(if_a.hCount), int'(if_a.vCount), int'(if_a.hSync),
                       int'(if_a.vSync), int'(if_a.bright));
            check_port("b", k, 640, 16, 96, 48, 480, 10, 2, 33, 1,
                       int'(if_b.hCount), int'(if_b.vCount), int'(if_b.hSync),
                       int'(if_b.vSync), int'(if_b.bright));
            check_port("c", k, 8, 2, 3, 2, 4, 1, 2, 1, 2,
                       int'(if_c.hCount), int'(if_c.vCount), int'(if_c.hSync),
                       int'(if_c.vSync), int'(if_c.bright));
            case (k)
                0:    chk_a("a_origin", 0, 0, 1, 1, 1);
                3:    chk_a("a_hold3", 0, 0, 1, 1, 1);
                4:    chk_a("a_tick1", 1, 0, 1, 1, 1);
                2556: chk_a("a_h639", 639, 0, 1, 1, 1);
                2560: chk_a("a_h640", 640, 0, 1, 1, 0);
                2620: chk_a("a_h655", 655, 0, 1, 1, 0);
                2624: chk_a("a_h656", 656, 0, 0, 1, 0);
                3004: chk_a("a_h751", 751, 0, 0, 1, 0);
                3008: chk_a("a_h752", 752, 0, 1, 1, 0);
                3196: chk_a("a_h799", 799, 0, 1, 1, 0);
                3200: chk_a("a_line1", 0, 1, 1, 1, 1);
                default: ;
            endcase
            case (k)
                0:   chk_b("b_origin", 0, 0, 1, 1);
                1:   chk_b("b_tick1", 1, 0, 1, 1);
                639: chk_b("b_h639", 639, 0, 1, 1);
                640: chk_b("b_h640", 640, 0, 1, 0);
                656: chk_b("b_h656", 656, 0, 0, 0);
                752: chk_b("b_h752", 752, 0, 1, 0);
                800: chk_b("b_line1", 0, 1, 1, 1);
                default: ;
            endcase
            case (k)
                120: chk_c("c_v4", 0, 4, 1, 0);
                149: chk_c("c_pre_vs", 14, 4, 1, 0);
                150: chk_c("c_vs_on", 0, 5, 0, 0);
                180: chk_c("c_vs_2nd", 0, 6, 0, 0);
                210: chk_c("c_vs_off", 0, 7, 1, 0);
                239: chk_c("c_last", 14, 7, 1, 0);
                240: chk_c("c_wrap", 0, 0, 1, 1);
                480: chk_c("c_wrap2", 0, 0, 1, 1);
                default: ;
            endcase
            @(negedge clock);
        end

        // Position (700,3): hSync low; clear lands between clock edges.
        #1;
        chk_a("a_pre_clear", 700, 3, 0, 1, 0);
        #1;
        clr_a = 1'b1;
        #1;
        chk_a("a_async_clear", 0, 0, 1, 1, 0);
        repeat (3) @(negedge clock);
        #1;
        chk_a("a_clear_hold", 0, 0, 1, 1, 0);
        @(negedge clock);
        clr_a = 1'b0;

        for (int k = 0; k <= 3300; k++) begin
            #1;
            check_port("a_rst", k, 640, 16, 96, 48, 480, 10, 2, 33, 4,
                       int'(if_a.hCount), int'(if_a.vCount), int'(if_a.hSync),
                       int'(if_a.vSync), int'(if_a.bright));
            case (k)
                0:    chk_a("a_restart", 0, 0, 1, 1, 1);
                3:    chk_a("a_restart_hold", 0, 0, 1, 1, 1);
                4:    chk_a("a_restart_tick", 1, 0, 1, 1, 1);
                3200: chk_a("a_restart_line1", 0, 1, 1, 1, 1);
                default: ;
            endcase
            @(negedge clock);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
